// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the stream multiplexer family.
//   mode_e  : selection mode (fixed external select / round-robin)
//   ptr_inc : modulo-N increment used for rotating-priority pointers
// -----------------------------------------------------------------------------
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Next pointer after index idx in a ring of nch entries.
  function automatic int unsigned ptr_inc(input int unsigned idx,
                                          input int unsigned nch);
    return (idx >= nch - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational rotate-priority search: grants the first requester
// found starting at ptr and wrapping modulo NCH.
// Ports:
//   req       [NCH]  request vector
//   ptr       [SELW] highest-priority index this cycle (expected < NCH)
//   gnt_idx   [SELW] granted index (0 when nothing is granted)
//   gnt_valid        at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NCH  = 8,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_valid
);

  int idx;

  // NOTE: every output gets a default before any conditional assignment so
  // that no path leaves it unassigned, which would infer a latch.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    // Scan from the farthest offset down to 0; the last hit written is the
    // nearest one to ptr, so no early exit is needed.
    for (int off = NCH - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= NCH) idx = idx - NCH;
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SELW'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// -----------------------------------------------------------------------------
// stream_mux_rr
// N-channel, W-bit valid/ready stream multiplexer with a single-entry output
// holding register. Channel selection is either a fixed external select or
// round-robin arbitration.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_data  [NCH*W]    channel i at bits [i*W +: W]
//   in_valid [NCH]      per-channel valid
//   in_ready [NCH]      per-channel accept (at most one bit set)
//   mode                0 = fixed select, 1 = round-robin
//   sel      [SELW]     fixed-mode channel; values >= NCH select nothing
//   out_data [W]        registered output word
//   out_ch   [SELW]     channel that produced out_data
//   out_valid           holding register is full
//   out_ready           consumer accept
// -----------------------------------------------------------------------------
module stream_mux_rr
  import mux_pkg::*;
#(
  parameter int NCH  = 8,
  parameter int W    = 8,
  parameter int SELW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH*W-1:0]  in_data,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_ch,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [W-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0] out_ch_q,   out_ch_d;
  logic            out_valid_q, out_valid_d;
  logic [SELW-1:0] rr_ptr_q,   rr_ptr_d;

  logic            load;
  logic            rr_gnt_valid;
  logic [SELW-1:0] rr_gnt_idx;
  logic            fix_gnt_valid;
  logic            grant_valid;
  logic [SELW-1:0] grant_idx;
  logic [W-1:0]    grant_data;
  logic            take;

  rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_rr_arbiter (
    .req       (in_valid),
    .ptr       (rr_ptr_q),
    .gnt_idx   (rr_gnt_idx),
    .gnt_valid (rr_gnt_valid)
  );

  // Holding register can accept when empty or when being drained this cycle.
  assign load = ~out_valid_q | out_ready;

  // Fixed select: compare against every real channel so an out-of-range sel
  // simply matches nothing.
  always_comb begin
    fix_gnt_valid = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(sel) == i) fix_gnt_valid = in_valid[i];
    end
  end

  assign grant_valid = (mode == MODE_RR) ? rr_gnt_valid : fix_gnt_valid;
  assign grant_idx   = (mode == MODE_RR) ? rr_gnt_idx   : sel;

  // in_ready is held low during reset so no handshake completes then.
  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant_idx == SELW'(i)) begin
        in_ready[i] = rst_n & load & grant_valid;
        grant_data  = in_data[i*W +: W];
      end
    end
  end

  assign take = |(in_valid & in_ready);

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (take) begin
      // Covers both refill of an empty register and drain-plus-refill.
      out_data_d  = grant_data;
      out_ch_d    = grant_idx;
      out_valid_d = 1'b1;
      if (mode == MODE_RR) rr_ptr_d = SELW'(ptr_inc(int'(grant_idx), NCH));
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its next-state value from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule
